// File: rtl/norm_pack.sv
// norm_pack: FP adder back end that normalises, rounds to nearest-even and packs an IEEE-754 single.
// Build option NORM_PACK_LZC_EN: single-cycle leading-zero shift instead of the iterative NORM state.
module norm_pack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28,
  parameter int FRAC_W = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+MANT_W:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+FRAC_W:0]       out_data,
  output logic                        out_ovf,
  output logic                        out_unf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic                sign_r, sign_s;
  logic [MANT_W-1:0]   mant_r, mant_s;
  logic [EXP_W:0]      exp_r, exp_s;
  logic [31:0]         data_r, data_s;
  logic                ovf_r, ovf_s;
  logic                unf_r, unf_s;
  logic                in_ready_r, out_valid_r;
  logic                inc_s;
  logic [23:0]         frac_sum_s;
  logic [8:0]          exp_rnd_s;

`ifdef NORM_PACK_LZC_EN
  logic [4:0]          lzc_s;

  function automatic logic [4:0] lzc27(input logic [26:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n     = n + 5'd1;
      end
    end
    return n;
  endfunction

  assign lzc_s = lzc27(mant_r[26:0]);
`endif

  // Round-to-nearest-even; the hidden bit is always set in ROUND, so a carry out of the
  // fraction is exactly the carry out of the 24-bit significand (sig becomes 0x800000).
  always_comb begin
    inc_s      = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    frac_sum_s = {1'b0, mant_r[25:3]} + {23'd0, inc_s};
    exp_rnd_s  = exp_r + {8'd0, frac_sum_s[23]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = CHECK;
        else          state_s = IDLE;
      end
      CHECK: begin
        if (mant_r == 28'd0 || exp_r == 9'h0FF || exp_r == 9'h000) state_s = DONE;
        else if (mant_r[27] || mant_r[26])                       state_s = ROUND;
        else begin
`ifdef NORM_PACK_LZC_EN
          if ({4'd0, lzc_s} >= exp_r) state_s = DONE;
          else                        state_s = ROUND;
`else
          state_s = NORM;
`endif
        end
      end
      NORM: begin
        if (exp_r == 9'd1)   state_s = DONE;
        else if (mant_r[25]) state_s = ROUND;
        else                 state_s = NORM;
      end
      ROUND: state_s = DONE;
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and result computation per state
  always_comb begin
    sign_s = sign_r;
    mant_s = mant_r;
    exp_s  = exp_r;
    data_s = data_r;
    ovf_s  = ovf_r;
    unf_s  = unf_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_s = in_data[36];
          exp_s  = {1'b0, in_data[35:28]};
          mant_s = in_data[27:0];
        end else begin
          sign_s = sign_r;
        end
      end
      CHECK: begin
        if (mant_r == 28'd0) begin
          data_s = 32'h0000_0000;
          ovf_s  = 1'b0;
          unf_s  = 1'b0;
        end else if (exp_r == 9'h0FF) begin
          data_s = {sign_r, 8'hFF, 23'd0};
          ovf_s  = 1'b1;
          unf_s  = 1'b0;
        end else if (exp_r == 9'h000) begin
          data_s = {sign_r, 31'd0};
          ovf_s  = 1'b0;
          unf_s  = 1'b1;
        end else if (mant_r[27]) begin
          mant_s = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
          exp_s  = exp_r + 9'd1;
        end else if (mant_r[26]) begin
          mant_s = mant_r;
        end else begin
`ifdef NORM_PACK_LZC_EN
          if ({4'd0, lzc_s} >= exp_r) begin
            data_s = {sign_r, 31'd0};
            ovf_s  = 1'b0;
            unf_s  = 1'b1;
          end else begin
            mant_s = mant_r << lzc_s;
            exp_s  = exp_r - {4'd0, lzc_s};
          end
`else
          mant_s = mant_r;
`endif
        end
      end
      NORM: begin
        if (exp_r == 9'd1) begin
          data_s = {sign_r, 31'd0};
          ovf_s  = 1'b0;
          unf_s  = 1'b1;
        end else begin
          mant_s = {mant_r[26:0], 1'b0};
          exp_s  = exp_r - 9'd1;
        end
      end
      ROUND: begin
        if (exp_rnd_s >= 9'h0FF) begin
          data_s = {sign_r, 8'hFF, 23'd0};
          ovf_s  = 1'b1;
          unf_s  = 1'b0;
        end else begin
          data_s = {sign_r, exp_rnd_s[7:0], frac_sum_s[22:0]};
          ovf_s  = 1'b0;
          unf_s  = 1'b0;
        end
      end
      DONE: begin
        data_s = data_r;
      end
      default: begin
        data_s = data_r;
      end
    endcase
  end

  // Operand/result registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r      <= 1'b0;
      mant_r      <= 28'd0;
      exp_r       <= 9'd0;
      data_r      <= 32'd0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      sign_r      <= sign_s;
      mant_r      <= mant_s;
      exp_r       <= exp_s;
      data_r      <= data_s;
      ovf_r       <= ovf_s;
      unf_r       <= unf_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = data_r;
  assign out_ovf   = ovf_r;
  assign out_unf   = unf_r;

endmodule

// File: tb/tb_norm_pack.sv
// Directed testbench for norm_pack: vector table plus hand-written backpressure and reset-abort sequences.
module tb_norm_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  always #5 clk = ~clk;

  norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [36:0] din;
    logic [31:0] dout;
    logic        ovf;
    logic        unf;
    int          lat_it;
    int          lat_lz;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic logic [36:0] mk(input logic s, input logic [7:0] e, input logic [27:0] m);
    return {s, e, m};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic run_op(input logic [36:0] d, output logic [31:0] dat, output logic ovf,
                        output logic unf, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    dat = out_data;
    ovf = out_ovf;
    unf = out_unf;
    if (out_valid) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] dat;
    logic        ovf, unf;
    int          lat, elat;
    logic        seen;

    vecs[0]  = '{mk(1'b0, 8'h7F, 28'h8000000), 32'h4000_0000, 1'b0, 1'b0, 3,  3};
    vecs[1]  = '{mk(1'b0, 8'h7F, 28'h0000008), 32'h3400_0000, 1'b0, 1'b0, 26, 3};
    vecs[2]  = '{mk(1'b0, 8'h7F, 28'h4000004), 32'h3F80_0000, 1'b0, 1'b0, 3,  3};
    vecs[3]  = '{mk(1'b0, 8'h7F, 28'h400000C), 32'h3F80_0002, 1'b0, 1'b0, 3,  3};
    vecs[4]  = '{mk(1'b0, 8'h7F, 28'h7FFFFFC), 32'h4000_0000, 1'b0, 1'b0, 3,  3};
    vecs[5]  = '{mk(1'b0, 8'hFE, 28'h8000000), 32'h7F80_0000, 1'b1, 1'b0, 3,  3};
    vecs[6]  = '{mk(1'b0, 8'h02, 28'h0000008), 32'h0000_0000, 1'b0, 1'b1, 4,  2};
    vecs[7]  = '{mk(1'b1, 8'h55, 28'h0000000), 32'h0000_0000, 1'b0, 1'b0, 2,  2};
    vecs[8]  = '{mk(1'b1, 8'hFF, 28'h4000000), 32'hFF80_0000, 1'b1, 1'b0, 2,  2};
    vecs[9]  = '{mk(1'b1, 8'h00, 28'h4000000), 32'h8000_0000, 1'b0, 1'b1, 2,  2};
    vecs[10] = '{mk(1'b1, 8'h80, 28'h2000000), 32'hBF80_0000, 1'b0, 1'b0, 4,  3};
    vecs[11] = '{mk(1'b0, 8'h7F, 28'h4000006), 32'h3F80_0001, 1'b0, 1'b0, 3,  3};
    vecs[12] = '{mk(1'b0, 8'h7F, 28'hC000003), 32'h4040_0000, 1'b0, 1'b0, 3,  3};
    vecs[13] = '{mk(1'b0, 8'hFE, 28'h7FFFFFC), 32'h7F80_0000, 1'b1, 1'b0, 3,  3};
    vecs[14] = '{mk(1'b0, 8'h02, 28'h2000000), 32'h0080_0000, 1'b0, 1'b0, 4,  3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 37'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  0, {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  0, out_data,           32'd0);
    chk("rst_out_ovf",   0, {31'd0, out_ovf},   32'd0);
    chk("rst_out_unf",   0, {31'd0, out_unf},   32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].din, dat, ovf, unf, lat);
`ifdef NORM_PACK_LZC_EN
      elat = vecs[i].lat_lz;
`else
      elat = vecs[i].lat_it;
`endif
      chk("vec_data",    i, dat,            vecs[i].dout);
      chk("vec_ovf",     i, {31'd0, ovf},   {31'd0, vecs[i].ovf});
      chk("vec_unf",     i, {31'd0, unf},   {31'd0, vecs[i].unf});
      chk("vec_latency", i, lat,            elat);
    end

    // Backpressure: result must hold while out_ready stays low.
    in_valid = 1'b1;
    in_data  = vecs[0].din;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_latency", 0, lat, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_data",      c, out_data,           32'h4000_0000);
      chk("hold_valid",     c, {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready",  c, {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_in_ready", 0, {31'd0, in_ready}, 32'd1);

    // Reset two cycles after the handshake aborts the operation.
    in_valid = 1'b1;
    in_data  = vecs[1].din;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  0, {31'd0, in_ready},  32'd1);
    chk("abort_out_valid", 0, {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_never_valid", 0, {31'd0, seen}, 32'd0);

    run_op(vecs[3].din, dat, ovf, unf, lat);
    chk("post_rst_data",    0, dat,          32'h3F80_0002);
    chk("post_rst_flags",   0, {30'd0, ovf, unf}, 32'd0);
    chk("post_rst_latency", 0, lat,          3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
